fir_filter_output_stage: RTL and testbench

Final stage of the FIR filter pipeline, directly downstream of the accumulate-stage pipeline register. It takes each signed accumulator value and its valid flag, rescales it with round-half-up and a right shift, and saturates it to the output sample width. Results are buffered in a small FIFO and presented to the consumer over a valid/ready handshake. When the FIFO is full it drives `freeze_out` back into the pipeline so upstream stages, including the accumulate-stage register, hold their contents.

---
 rtl/fir_filter_output_stage.sv | 108 ++++++++++
 tb/tb_fir_filter_output_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_output_stage.sv
// rtl/fir_filter_output_stage.sv - FIR output stage: round, saturate, buffer, handshake
// Rescales accumulator values, clips to the sample width and queues them for the consumer.
module fir_filter_output_stage #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [IN_WIDTH-1:0]  accum_value_in,
    input  logic                 output_valid_in,
    output logic                 freeze_out,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          sat_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Half an output LSB; shifting right afterwards keeps SHIFT=0 free of a negative shift.
    localparam logic signed [IN_WIDTH:0] ROUND =
        (((IN_WIDTH+1)'(1)) << SHIFT) >> 1;
    localparam logic signed [IN_WIDTH:0] MAX_VAL =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MIN_VAL =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] rounded;
    logic signed [IN_WIDTH:0] shifted;
    logic                     over;
    logic                     under;
    logic                     sat;
    logic [OUT_WIDTH-1:0]     sample;

    assign ext     = {accum_value_in[IN_WIDTH-1], accum_value_in};
    assign rounded = ext + ROUND;
    assign shifted = rounded >>> SHIFT;
    assign over    = shifted > MAX_VAL;
    assign under   = shifted < MIN_VAL;
    assign sat     = over | under;

    always_comb begin
        sample = shifted[OUT_WIDTH-1:0];
        if (over) begin
            sample = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (under) begin
            sample = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;

    // Status comes from the registered count only, keeping handshake inputs off these paths.
    assign freeze_out = (count == FULL_COUNT);
    assign out_valid  = (count != '0);
    assign out_data   = mem[rd_ptr];

    assign push = output_valid_in & ~freeze_out & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (push && sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fir_filter_output_stage.sv
// tb/tb_fir_filter_output_stage.sv - self-checking bench for fir_filter_output_stage
// Directed and randomized steps compared against a queue-based arithmetic reference model.
module tb_fir_filter_output_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] accum_value_in;
    logic        output_valid_in;
    logic        freeze_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sat_count;

    fir_filter_output_stage #(
        .IN_WIDTH (32),
        .OUT_WIDTH(16),
        .SHIFT    (15),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .accum_value_in (accum_value_in),
        .output_valid_in(output_valid_in),
        .freeze_out     (freeze_out),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .sat_count      (sat_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] q[$];
    int          sat_model = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: floor((v + 2^14) / 2^15), then clamp to the int16 range.
    task automatic ref_scale(input logic [31:0] v, output logic [15:0] o, output bit s);
        longint x, num, d, r;
        x   = longint'($signed(v));
        num = x + 64'sd16384;
        d   = 64'sd32768;
        r   = num / d;
        if ((num < 0) && ((num % d) != 0)) r = r - 1;
        s = 1'b0;
        if (r > 32767) begin
            o = 16'h7FFF; s = 1'b1;
        end else if (r < -32768) begin
            o = 16'h8000; s = 1'b1;
        end else begin
            o = r[15:0];
        end
    endtask

    task automatic compare_state(input string tag);
        check({tag, "_valid"},  {31'd0, out_valid},  {31'd0, q.size() > 0});
        check({tag, "_freeze"}, {31'd0, freeze_out}, {31'd0, q.size() == DEPTH});
        check({tag, "_satcnt"}, {16'd0, sat_count},  sat_model);
        if (q.size() > 0) check({tag, "_data"}, {16'd0, out_data}, {16'd0, q[0]});
    endtask

    task automatic step(input bit v, input logic [31:0] val, input bit rd, input bit fl,
                        input string tag, output bit pushed);
        logic [15:0] o;
        bit          s;
        bit          popped;
        rst             = 1'b0;
        accum_value_in  = val;
        output_valid_in = v;
        out_ready       = rd;
        flush           = fl;
        ref_scale(val, o, s);
        pushed = v && !fl && (q.size() < DEPTH);
        popped = rd && !fl && (q.size() > 0);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (popped) void'(q.pop_front());
            if (pushed) begin
                q.push_back(o);
                if (s && sat_model < 16'hFFFF) sat_model++;
            end
        end
        compare_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst             = 1'b1;
        flush           = 1'b0;
        output_valid_in = 1'b1;
        accum_value_in  = 32'h7FFF_FFFF;
        out_ready       = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        sat_model = 0;
        check({tag, "_rst_valid"},  {31'd0, out_valid},  0);
        check({tag, "_rst_freeze"}, {31'd0, freeze_out}, 0);
        check({tag, "_rst_data"},   {16'd0, out_data},   0);
        check({tag, "_rst_satcnt"}, {16'd0, sat_count},  0);
    endtask

    task automatic drain(input string tag);
        bit p;
        for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, 32'd0, 1'b1, 1'b0, tag, p);
        check({tag, "_drained"}, {31'd0, out_valid}, 0);
    endtask

    initial begin : main
        bit          p;
        int          idx;
        int          guard;
        logic [31:0] rnd_in [4];
        logic [15:0] rnd_out[4];
        logic [31:0] v;
        int          sat_before;

        rst = 1'b1; flush = 1'b0; accum_value_in = '0; output_valid_in = 1'b0; out_ready = 1'b0;
        do_reset("init");

        // Rounding
        rnd_in[0] = 32'h0000_4000; rnd_out[0] = 16'h0001;
        rnd_in[1] = 32'h0000_3FFF; rnd_out[1] = 16'h0000;
        rnd_in[2] = 32'hFFFF_C000; rnd_out[2] = 16'h0000;
        rnd_in[3] = 32'hFFFF_BFFF; rnd_out[3] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rnd_in[i], 1'b1, 1'b0, "round", p);
            check($sformatf("round_const%0d", i), {16'd0, out_data}, {16'd0, rnd_out[i]});
        end
        drain("round");
        check("round_satcnt_zero", {16'd0, sat_count}, 0);

        // Saturation
        rnd_in[0] = 32'h4000_0000; rnd_out[0] = 16'h7FFF;
        rnd_in[1] = 32'h7FFF_FFFF; rnd_out[1] = 16'h7FFF;
        rnd_in[2] = 32'h8000_0000; rnd_out[2] = 16'h8000;
        rnd_in[3] = 32'h3FFF_BFFF; rnd_out[3] = 16'h7FFF;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rnd_in[i], 1'b1, 1'b0, "sat", p);
            check($sformatf("sat_const%0d", i), {16'd0, out_data}, {16'd0, rnd_out[i]});
        end
        drain("sat");
        check("sat_count_three", {16'd0, sat_count}, 3);

        // Backpressure: upstream holds the same value until it is accepted
        idx = 1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, idx << 15, 1'b0, 1'b0, "bp_fill", p);
            if (p) idx++;
        end
        check("bp_freeze_after4", {31'd0, freeze_out}, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, idx << 15, 1'b0, 1'b0, "bp_frozen", p);
            check("bp_not_accepted", {31'd0, freeze_out}, 1);
        end
        step(1'b1, idx << 15, 1'b1, 1'b0, "bp_first_pop", p);
        if (p) idx++;
        check("bp_freeze_drop", {31'd0, freeze_out}, 0);
        guard = 0;
        while (idx <= 6 && guard < 30) begin
            step(1'b1, idx << 15, 1'b1, 1'b0, "bp_resume", p);
            if (p) idx++;
            guard++;
        end
        check("bp_all_accepted", idx, 7);
        drain("bp");

        // Simultaneous push/pop at count 2 across pointer wrap
        step(1'b1, $urandom, 1'b0, 1'b0, "pp_fill", p);
        step(1'b1, $urandom_range(0, 32'h00FF_FFFF), 1'b0, 1'b0, "pp_fill", p);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom_range(0, 32'h01FF_FFFF) - 32'h00FF_FFFF, 1'b1, 1'b0, "pp", p);
            check("pp_count_two", q.size(), 2);
        end
        drain("pp");

        // Flush with three buffered entries
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, "fl_fill", p);
        sat_before = sat_model;
        step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "fl", p);
        check("fl_valid_low",  {31'd0, out_valid},  0);
        check("fl_freeze_low", {31'd0, freeze_out}, 0);
        check("fl_sat_hold",   {16'd0, sat_count},  sat_before);
        step(1'b0, 32'd0, 1'b1, 1'b0, "fl_after", p);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 1) == 1) ? $urandom
                                            : ($urandom_range(0, 32'h0080_0000) - 32'h0040_0000);
            step($urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, "rand", p);
        end

        // Reset mid-operation with full FIFO and sat_count 5
        do_reset("mid_pre");
        for (int i = 0; i < 4; i++) step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, "mid_fill", p);
        step(1'b1, 32'h8000_0000, 1'b1, 1'b0, "mid_pop", p);
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, "mid_refill", p);
        check("mid_full",   {31'd0, freeze_out}, 1);
        check("mid_sat5",   {16'd0, sat_count},  5);
        do_reset("mid");
        step(1'b1, 32'h0000_8000, 1'b0, 1'b0, "post_rst", p);
        check("post_rst_data",  {16'd0, out_data},  16'h0001);
        check("post_rst_valid", {31'd0, out_valid}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
